lsu_initiator: RTL
==================

Name: lsu_initiator

Overview:
- Load/store initiator that drives the core's data-side memory interface as the requesting end.
- Accepts one core load/store request at a time and checks alignment and size.
- Generates the word-aligned address, byte strobes and lane-replicated write data, then issues a single-cycle `memory_valid` pulse.
- Waits for `memory_ready`, then returns the extracted, sign- or zero-extended load data to the core with a completion pulse.

Parameters:
- timeout_cycles, 255: WAIT cycles without `memory_ready` before the request is abandoned with a timeout error (1..65535).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- lsu_valid  in  1  core request strobe; sampled only in IDLE.
- lsu_store  in  1  1 = store, 0 = load.
- lsu_size  in  2  0 byte, 1 half, 2 word, 3 illegal.
- lsu_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- lsu_addr  in  32  byte address.
- lsu_wdata  in  32  store data, right-justified.
- lsu_busy  out  1  high in every state except IDLE.
- lsu_ready  out  1  one-cycle completion pulse.
- lsu_rdata  out  32  load result; valid while `lsu_ready`=1; 0 for stores and errors.
- lsu_error  out  1  valid with `lsu_ready`.
- lsu_cause  out  2  0 none, 1 misaligned, 2 illegal size, 3 timeout.
- memory_valid  out  1  request pulse.
- memory_instr  out  1  tied 0 (data access).
- memory_addr  out  32  {addr[31:2],2'b00}.
- memory_wdata  out  32  lane-replicated store data.
- memory_wstrb  out  4  byte strobes; 0000 for loads.
- memory_rdata  in  32  response word.
- memory_ready  in  1  response strobe.

Behaviour:
- Reset: state IDLE; all outputs and registers 0; the timeout counter is cleared. Reset asserted mid-transaction abandons it immediately, with no `lsu_ready` afterwards.
- States: IDLE, REQ, WAIT, RESP. All outputs are registered.
- IDLE:
  - On `lsu_valid`, latch all request fields.
  - Illegal size (3) -> RESP with cause 2.
  - Misaligned (half with addr[0]=1, or word with addr[1:0]!=0) -> RESP with cause 1.
  - Otherwise -> REQ.
  - No memory access is made on an error.
- REQ: `memory_valid`=1 with addr/wdata/wstrb for exactly one cycle -> WAIT. `memory_valid` must never be high for two consecutive cycles, because the responder re-executes writes while valid is held.
- WAIT: `memory_valid`=0 and the counter increments.
  - `memory_ready`=1 -> RESP with cause 0, capturing `memory_rdata`.
  - Counter reaching timeout_cycles -> RESP with cause 3.
  - If ready and timeout occur in the same cycle, ready wins.
- RESP: `lsu_ready`=1 for one cycle with rdata/error/cause -> IDLE. `lsu_valid` may be accepted in the cycle after RESP.
- Nominal latency with a one-cycle responder: request accepted at cycle N, `memory_valid` at N+1, `memory_ready` at N+2, `lsu_ready` at N+3. An error request gives `lsu_ready` at N+1.
- `memory_ready` seen in IDLE/REQ/RESP is ignored; this covers late responses after a timeout.
- `lsu_valid` is ignored while `lsu_busy`=1; the core must hold off.
- Stores:
  - Byte: wstrb = 0001<<addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Half: wstrb = 0011<<{addr[1],1'b0}; wdata = {2{wdata[15:0]}}.
  - Word: wstrb 1111, wdata unchanged.
- Loads:
  - Byte lane is addr[1:0]; half lane is addr[1].
  - Extend to 32 bits per `lsu_unsigned`.
- Stores return `lsu_rdata`=0.

Decomposition:
- configure package gets the size encodings (lsb_byte/half/word), the cause codes, and the state enum type.
- Sub-module lsu_align, purely combinational:
  - store side: size, addr[1:0], wdata -> wstrb, replicated wdata;
  - load side: size, unsigned, addr[1:0], raw word -> extended rdata.
- The FSM and timeout counter stay in lsu_initiator.

Test Plan:
- Store byte 0xA5 at 0x0000_1003 -> `memory_valid` one cycle, addr 0x0000_1000, wstrb 1000, wdata 0xA5A5A5A5; `lsu_ready` 3 cycles after accept, cause 0.
- Load half signed at 0x0000_2002 with memory word 0x8001_1234 -> `lsu_rdata` 0xFFFF_8001; unsigned -> 0x0000_8001; wstrb 0000.
- Load word at 0x0000_3001 -> no `memory_valid`; `lsu_ready` next cycle, error=1, cause=1. Size 3 -> cause 2.
- Responder never asserts ready, timeout_cycles=8 -> `lsu_ready` with cause 3 after 8 WAIT cycles. A later stray `memory_ready` is ignored, and the next load completes normally.
- Back-to-back: `lsu_valid` held high across 3 word stores -> each store gets exactly one `memory_valid` pulse, `lsu_busy` is high between them, and the memory contents match.
- Drop rst to 0 during WAIT -> all outputs 0 asynchronously; after release, state is IDLE and no `lsu_ready` is emitted for the aborted request.

Source files
------------

// File: rtl/lsu_initiator_pkg.sv
// Shared encodings for the load/store initiator: access sizes, completion
// cause codes, FSM state type and the alignment check helper.
package lsu_initiator_pkg;

    // Access size encodings as presented on lsu_size
    localparam logic [1:0] LSB_BYTE    = 2'd0;
    localparam logic [1:0] LSB_HALF    = 2'd1;
    localparam logic [1:0] LSB_WORD    = 2'd2;
    localparam logic [1:0] LSB_ILLEGAL = 2'd3;

    // Completion cause codes returned on lsu_cause
    localparam logic [1:0] CAUSE_NONE         = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGNED   = 2'd1;
    localparam logic [1:0] CAUSE_ILLEGAL_SIZE = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT      = 2'd3;

    // Transaction FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // A half access needs an even address, a word access a multiple of four.
    // Bytes are always aligned; the illegal size is rejected separately.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (size)
            LSB_HALF: mis = addr_lo[0];
            LSB_WORD: mis = (addr_lo != 2'b00);
            default:  mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_initiator_align.sv
// Purely combinational lane steering for the initiator.
// Store side: byte strobes and lane-replicated write data.
// Load side: lane extraction plus sign/zero extension of the response word.
module lsu_align
    import lsu_initiator_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    output logic [31:0] st_wdata_rep,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    // Store strobes and replicated data; the illegal size produces no strobes
    always_comb begin
        st_wstrb     = 4'b0000;
        st_wdata_rep = 32'h0000_0000;
        case (st_size)
            LSB_BYTE: begin
                st_wstrb     = 4'b0001 << st_addr_lo;
                st_wdata_rep = {4{st_wdata[7:0]}};
            end
            LSB_HALF: begin
                st_wstrb     = 4'b0011 << {st_addr_lo[1], 1'b0};
                st_wdata_rep = {2{st_wdata[15:0]}};
            end
            LSB_WORD: begin
                st_wstrb     = 4'b1111;
                st_wdata_rep = st_wdata;
            end
            default: begin
                st_wstrb     = 4'b0000;
                st_wdata_rep = 32'h0000_0000;
            end
        endcase
    end

    // Select the addressed byte and half lanes of the response word
    always_comb begin
        ld_byte_s = 8'h00;
        case (ld_addr_lo)
            2'd0:    ld_byte_s = ld_raw[7:0];
            2'd1:    ld_byte_s = ld_raw[15:8];
            2'd2:    ld_byte_s = ld_raw[23:16];
            2'd3:    ld_byte_s = ld_raw[31:24];
            default: ld_byte_s = 8'h00;
        endcase
        if (ld_addr_lo[1]) begin
            ld_half_s = ld_raw[31:16];
        end else begin
            ld_half_s = ld_raw[15:0];
        end
    end

    // Extend the selected lane to 32 bits
    always_comb begin
        ld_data = 32'h0000_0000;
        case (ld_size)
            LSB_BYTE: begin
                if (ld_unsigned) begin
                    ld_data = {24'h00_0000, ld_byte_s};
                end else begin
                    ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
                end
            end
            LSB_HALF: begin
                if (ld_unsigned) begin
                    ld_data = {16'h0000, ld_half_s};
                end else begin
                    ld_data = {{16{ld_half_s[15]}}, ld_half_s};
                end
            end
            LSB_WORD: ld_data = ld_raw;
            default:  ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_initiator.sv
// Load/store initiator: accepts one core request, validates it, issues a
// single-cycle memory request, waits (bounded) for the response and returns
// the extended load data with a one-cycle completion pulse.
module lsu_initiator
    import lsu_initiator_pkg::*;
#(
    parameter int unsigned timeout_cycles = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    input  logic        lsu_store,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_unsigned,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_busy,
    output logic        lsu_ready,
    output logic [31:0] lsu_rdata,
    output logic        lsu_error,
    output logic [1:0]  lsu_cause,
    output logic        memory_valid,
    output logic        memory_instr,
    output logic [31:0] memory_addr,
    output logic [31:0] memory_wdata,
    output logic [3:0]  memory_wstrb,
    input  logic [31:0] memory_rdata,
    input  logic        memory_ready
);

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(timeout_cycles);

    // Registered state and latched request fields
    lsu_state_e  state_r;
    logic        req_store_r;
    logic [1:0]  req_size_r;
    logic        req_unsigned_r;
    logic [1:0]  req_addr_lo_r;
    logic [15:0] wait_cnt_r;

    // Registered outputs
    logic        busy_r;
    logic        ready_r;
    logic [31:0] rdata_r;
    logic        error_r;
    logic [1:0]  cause_r;
    logic        mem_valid_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [3:0]  mem_wstrb_r;

    // Next-state values
    lsu_state_e  state_s;
    logic        req_store_s;
    logic [1:0]  req_size_s;
    logic        req_unsigned_s;
    logic [1:0]  req_addr_lo_s;
    logic [15:0] wait_cnt_s;
    logic [15:0] wait_cnt_inc_s;
    logic        busy_s;
    logic        ready_s;
    logic [31:0] rdata_s;
    logic        error_s;
    logic [1:0]  cause_s;
    logic        mem_valid_s;
    logic [31:0] mem_addr_s;
    logic [31:0] mem_wdata_s;
    logic [3:0]  mem_wstrb_s;

    // Lane steering outputs
    logic [3:0]  align_wstrb_s;
    logic [31:0] align_wdata_s;
    logic [31:0] align_rdata_s;

    // Store side works on the live request (used only at accept time);
    // load side works on the latched request and the response word.
    lsu_align u_align (
        .st_size      (lsu_size),
        .st_addr_lo   (lsu_addr[1:0]),
        .st_wdata     (lsu_wdata),
        .st_wstrb     (align_wstrb_s),
        .st_wdata_rep (align_wdata_s),
        .ld_size      (req_size_r),
        .ld_unsigned  (req_unsigned_r),
        .ld_addr_lo   (req_addr_lo_r),
        .ld_raw       (memory_rdata),
        .ld_data      (align_rdata_s)
    );

    assign wait_cnt_inc_s = wait_cnt_r + 16'd1;

    // FSM next state and next values for every registered output
    always_comb begin
        state_s        = state_r;
        req_store_s    = req_store_r;
        req_size_s     = req_size_r;
        req_unsigned_s = req_unsigned_r;
        req_addr_lo_s  = req_addr_lo_r;
        wait_cnt_s     = wait_cnt_r;
        ready_s        = 1'b0;
        rdata_s        = 32'h0000_0000;
        error_s        = 1'b0;
        cause_s        = CAUSE_NONE;
        mem_valid_s    = 1'b0;
        mem_addr_s     = mem_addr_r;
        mem_wdata_s    = mem_wdata_r;
        mem_wstrb_s    = mem_wstrb_r;

        case (state_r)
            ST_IDLE: begin
                wait_cnt_s = 16'd0;
                if (lsu_valid) begin
                    req_store_s    = lsu_store;
                    req_size_s     = lsu_size;
                    req_unsigned_s = lsu_unsigned;
                    req_addr_lo_s  = lsu_addr[1:0];
                    if (lsu_size == LSB_ILLEGAL) begin
                        state_s = ST_RESP;
                        ready_s = 1'b1;
                        error_s = 1'b1;
                        cause_s = CAUSE_ILLEGAL_SIZE;
                    end else if (is_misaligned(lsu_size, lsu_addr[1:0])) begin
                        state_s = ST_RESP;
                        ready_s = 1'b1;
                        error_s = 1'b1;
                        cause_s = CAUSE_MISALIGNED;
                    end else begin
                        state_s     = ST_REQ;
                        mem_valid_s = 1'b1;
                        mem_addr_s  = {lsu_addr[31:2], 2'b00};
                        if (lsu_store) begin
                            mem_wdata_s = align_wdata_s;
                            mem_wstrb_s = align_wstrb_s;
                        end else begin
                            mem_wdata_s = 32'h0000_0000;
                            mem_wstrb_s = 4'b0000;
                        end
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // memory_valid drops here: the responder must see one pulse only
                state_s    = ST_WAIT;
                wait_cnt_s = 16'd0;
            end
            ST_WAIT: begin
                // A response in the final WAIT cycle beats the timeout
                if (memory_ready) begin
                    state_s = ST_RESP;
                    ready_s = 1'b1;
                    cause_s = CAUSE_NONE;
                    if (req_store_r) begin
                        rdata_s = 32'h0000_0000;
                    end else begin
                        rdata_s = align_rdata_s;
                    end
                end else if (wait_cnt_inc_s == TIMEOUT_LIMIT) begin
                    state_s    = ST_RESP;
                    ready_s    = 1'b1;
                    error_s    = 1'b1;
                    cause_s    = CAUSE_TIMEOUT;
                    wait_cnt_s = 16'd0;
                end else begin
                    wait_cnt_s = wait_cnt_inc_s;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State, request latches and registered outputs; reset abandons any transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_IDLE;
            req_store_r    <= 1'b0;
            req_size_r     <= 2'd0;
            req_unsigned_r <= 1'b0;
            req_addr_lo_r  <= 2'd0;
            wait_cnt_r     <= 16'd0;
            busy_r         <= 1'b0;
            ready_r        <= 1'b0;
            rdata_r        <= 32'h0000_0000;
            error_r        <= 1'b0;
            cause_r        <= 2'd0;
            mem_valid_r    <= 1'b0;
            mem_addr_r     <= 32'h0000_0000;
            mem_wdata_r    <= 32'h0000_0000;
            mem_wstrb_r    <= 4'b0000;
        end else begin
            state_r        <= state_s;
            req_store_r    <= req_store_s;
            req_size_r     <= req_size_s;
            req_unsigned_r <= req_unsigned_s;
            req_addr_lo_r  <= req_addr_lo_s;
            wait_cnt_r     <= wait_cnt_s;
            busy_r         <= busy_s;
            ready_r        <= ready_s;
            rdata_r        <= rdata_s;
            error_r        <= error_s;
            cause_r        <= cause_s;
            mem_valid_r    <= mem_valid_s;
            mem_addr_r     <= mem_addr_s;
            mem_wdata_r    <= mem_wdata_s;
            mem_wstrb_r    <= mem_wstrb_s;
        end
    end

    assign lsu_busy     = busy_r;
    assign lsu_ready    = ready_r;
    assign lsu_rdata    = rdata_r;
    assign lsu_error    = error_r;
    assign lsu_cause    = cause_r;
    assign memory_valid = mem_valid_r;
    assign memory_instr = 1'b0;
    assign memory_addr  = mem_addr_r;
    assign memory_wdata = mem_wdata_r;
    assign memory_wstrb = mem_wstrb_r;

endmodule
